// File: rtl/jack_motion_ctrl.sv
// jack_motion_ctrl: PS/2 make/break decoder plus a once-per-frame walk, jump
// and gravity integrator for the Jack sprite. It also reports the
// facing/airborne/moving state word used by the sprite selector.
// Optional feature macro: JACK_JUMP_BUFFER_EN. When it is defined, a jump
// request raised in the air stays alive for up to 4 airborne ticks, so it can
// fire on the first tick back on the ground.
module jack_motion_ctrl #(
   parameter int unsigned X_W     = 10,
   parameter int unsigned Y_W     = 9,
   parameter int unsigned X_INIT  = 0,
   parameter int unsigned Y_INIT  = 0,
   parameter int unsigned X_MAX   = 504,
   parameter int unsigned Y_MAX   = 360,
   parameter int unsigned STEP_X  = 2,
   parameter int unsigned JUMP_V  = 8,
   parameter int unsigned GRAVITY = 1,
   parameter int unsigned VMAX    = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [7:0]     key_code,
   input  logic           key_valid,
   input  logic           frame_tick,
   input  logic           run,
   input  logic           on_ground,
   input  logic           head_block,
   output logic [X_W-1:0] x_pos,
   output logic [Y_W-1:0] y_pos,
   output logic [2:0]     state,
   output logic           jump_evt
);
   typedef enum logic [1:0] {ST_GROUND = 2'd0, ST_RISE = 2'd1, ST_FALL = 2'd2} vstate_t;

   localparam logic [7:0]   KC_BRK     = 8'hF0;
   localparam logic [7:0]   KC_EXT     = 8'hE0;
   localparam logic [7:0]   KC_A       = 8'h1C;
   localparam logic [7:0]   KC_D       = 8'h23;
   localparam logic [7:0]   KC_W       = 8'h1D;
   localparam logic [X_W:0] X_MAX_E    = (X_W+1)'(X_MAX);
   localparam logic [X_W:0] STEP_E     = (X_W+1)'(STEP_X);
   localparam logic [Y_W:0] Y_MAX_E    = (Y_W+1)'(Y_MAX);
   localparam logic [Y_W:0] JUMP_E     = (Y_W+1)'(JUMP_V);
   localparam logic [4:0]   GRAV_V     = 5'(GRAVITY);
   localparam logic [4:0]   VMAX_V     = 5'(VMAX);
   localparam logic [4:0]   VY_TAKEOFF = 5'(JUMP_V - GRAVITY);

   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   logic [4:0]     vy_q, vy_d;
   vstate_t        fsm_q, fsm_d;
   logic           facing_q, facing_d, moving_q, moving_d, jump_evt_q, jump_evt_d;
   logic           held_a_q, held_a_d, held_d_q, held_d_d, held_w_q, held_w_d;
   logic           brk_q, brk_d, ext_q, ext_d, jump_req_q, jump_req_d;
   logic           jump_set, tick;
`ifdef JACK_JUMP_BUFFER_EN
   logic [2:0]     age_q, age_d;
`endif

   // Saturating arithmetic. Each value is one bit wider so that overflow and
   // underflow are visible.
   logic [X_W:0]   x_ext, x_inc;
   logic [X_W-1:0] x_left, x_right;
   logic [Y_W:0]   y_ext, rise_amt, y_fall;
   logic [Y_W-1:0] y_rise;
   logic [5:0]     vy_inc;
   logic [4:0]     vy_fall_next, vy_rise_next;

   assign tick         = frame_tick && run;
   assign x_ext        = {1'b0, x_q};
   assign x_inc        = x_ext + STEP_E;
   assign x_left       = (x_ext >= STEP_E) ? (x_q - STEP_E[X_W-1:0]) : '0;
   assign x_right      = (x_inc > X_MAX_E) ? X_MAX_E[X_W-1:0] : x_inc[X_W-1:0];
   assign y_ext        = {1'b0, y_q};
   // Takeoff lifts by JUMP_V. A rising tick lifts by the current speed.
   assign rise_amt     = (fsm_q == ST_GROUND) ? JUMP_E : {{(Y_W-4){1'b0}}, vy_q};
   assign y_rise       = (y_ext >= rise_amt) ? (y_q - rise_amt[Y_W-1:0]) : '0;
   assign y_fall       = y_ext + {{(Y_W-4){1'b0}}, vy_q};
   assign vy_inc       = {1'b0, vy_q} + {1'b0, GRAV_V};
   assign vy_fall_next = (vy_inc > {1'b0, VMAX_V}) ? VMAX_V : vy_inc[4:0];
   assign vy_rise_next = (vy_q > GRAV_V) ? (vy_q - GRAV_V) : 5'd0;

   // Scan-byte decoder: prefix flags, held keys, and the fresh W-make strobe.
   always_comb begin
      held_a_d = held_a_q;
      held_d_d = held_d_q;
      held_w_d = held_w_q;
      brk_d    = brk_q;
      ext_d    = ext_q;
      jump_set = 1'b0;
      if (key_valid) begin
         if (key_code == KC_BRK) begin
            brk_d = 1'b1;
         end else if (key_code == KC_EXT) begin
            ext_d = 1'b1;
         end else begin
            brk_d = 1'b0;
            ext_d = 1'b0;
            if (!ext_q) begin
               case (key_code)
                  KC_A: held_a_d = !brk_q;
                  KC_D: held_d_d = !brk_q;
                  KC_W: begin
                     held_w_d = !brk_q;
                     jump_set = !brk_q && !held_w_q;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // Per-tick motion: horizontal walk, vertical FSM, and jump request lifetime.
   always_comb begin
      x_d        = x_q;
      y_d        = y_q;
      vy_d       = vy_q;
      fsm_d      = fsm_q;
      facing_d   = facing_q;
      moving_d   = moving_q;
      jump_evt_d = 1'b0;
      jump_req_d = jump_req_q;
`ifdef JACK_JUMP_BUFFER_EN
      age_d      = age_q;
`endif
      if (tick) begin
         if (held_a_q && !held_d_q) begin
            x_d      = x_left;
            facing_d = 1'b0;
         end else if (held_d_q && !held_a_q) begin
            x_d      = x_right;
            facing_d = 1'b1;
         end
         moving_d = (x_d != x_q);

         case (fsm_q)
            ST_GROUND: begin
               if (jump_req_q) begin
                  fsm_d      = ST_RISE;
                  y_d        = y_rise;
                  vy_d       = VY_TAKEOFF;
                  jump_evt_d = 1'b1;
                  jump_req_d = 1'b0;
`ifdef JACK_JUMP_BUFFER_EN
                  age_d      = 3'd0;
`endif
               end else if (!on_ground) begin
                  fsm_d = ST_FALL;
                  vy_d  = GRAV_V;
               end
            end
            ST_RISE: begin
               if (head_block || vy_q == 5'd0) begin
                  fsm_d = ST_FALL;
                  vy_d  = GRAV_V;
               end else begin
                  y_d  = y_rise;
                  vy_d = vy_rise_next;
               end
            end
            ST_FALL: begin
               if (on_ground) begin
                  fsm_d = ST_GROUND;
                  vy_d  = 5'd0;
               end else if (y_fall > Y_MAX_E) begin
                  y_d   = Y_MAX_E[Y_W-1:0];
                  fsm_d = ST_GROUND;
                  vy_d  = 5'd0;
               end else begin
                  y_d  = y_fall[Y_W-1:0];
                  vy_d = vy_fall_next;
               end
            end
            default: begin
               fsm_d = ST_GROUND;
               vy_d  = 5'd0;
            end
         endcase

         // A request pending on an airborne tick is dropped at once, or is
         // aged out after its fourth airborne tick when buffering is on.
         if (fsm_q != ST_GROUND) begin
`ifdef JACK_JUMP_BUFFER_EN
            if (jump_req_q) begin
               if (age_q >= 3'd4) begin
                  jump_req_d = 1'b0;
                  age_d      = 3'd0;
               end else begin
                  age_d = age_q + 3'd1;
               end
            end
`else
            jump_req_d = 1'b0;
`endif
         end
      end
      // A byte that arrives with a tick is applied after that tick.
      if (jump_set) begin
         jump_req_d = 1'b1;
`ifdef JACK_JUMP_BUFFER_EN
         age_d      = 3'd0;
`endif
      end
   end

   // State registers. Reset takes priority over any tick or byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q        <= X_W'(X_INIT);
         y_q        <= Y_W'(Y_INIT);
         vy_q       <= 5'd0;
         fsm_q      <= ST_GROUND;
         facing_q   <= 1'b1;
         moving_q   <= 1'b0;
         jump_evt_q <= 1'b0;
         held_a_q   <= 1'b0;
         held_d_q   <= 1'b0;
         held_w_q   <= 1'b0;
         brk_q      <= 1'b0;
         ext_q      <= 1'b0;
         jump_req_q <= 1'b0;
`ifdef JACK_JUMP_BUFFER_EN
         age_q      <= 3'd0;
`endif
      end else begin
         x_q        <= x_d;
         y_q        <= y_d;
         vy_q       <= vy_d;
         fsm_q      <= fsm_d;
         facing_q   <= facing_d;
         moving_q   <= moving_d;
         jump_evt_q <= jump_evt_d;
         held_a_q   <= held_a_d;
         held_d_q   <= held_d_d;
         held_w_q   <= held_w_d;
         brk_q      <= brk_d;
         ext_q      <= ext_d;
         jump_req_q <= jump_req_d;
`ifdef JACK_JUMP_BUFFER_EN
         age_q      <= age_d;
`endif
      end
   end

   assign x_pos    = x_q;
   assign y_pos    = y_q;
   assign state    = {moving_q, (fsm_q != ST_GROUND), facing_q};
   assign jump_evt = jump_evt_q;
endmodule

// File: tb/tb_jack_motion_ctrl.sv
// Scoreboard bench for jack_motion_ctrl. The driver advances a behavioural
// model of the player on every tick and queues the expected outputs. A monitor
// compares the queued values against the DUT one cycle after each tick or reset.
module tb_jack_motion_ctrl;
   localparam int X_W = 10, Y_W = 9, X_INIT = 0, Y_INIT = 0, X_MAX = 504, Y_MAX = 360;
   localparam int STEP_X = 2, JUMP_V = 8, GRAVITY = 1, VMAX = 8;
   localparam int PH_GROUND = 0, PH_RISE = 1, PH_FALL = 2;

   logic           clk = 1'b0;
   logic           rst, key_valid, frame_tick, run, on_ground, head_block;
   logic [7:0]     key_code;
   logic [X_W-1:0] x_pos;
   logic [Y_W-1:0] y_pos;
   logic [2:0]     state;
   logic           jump_evt;

   jack_motion_ctrl #(
      .X_W(X_W), .Y_W(Y_W), .X_INIT(X_INIT), .Y_INIT(Y_INIT), .X_MAX(X_MAX),
      .Y_MAX(Y_MAX), .STEP_X(STEP_X), .JUMP_V(JUMP_V), .GRAVITY(GRAVITY), .VMAX(VMAX)
   ) dut (
      .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
      .frame_tick(frame_tick), .run(run), .on_ground(on_ground), .head_block(head_block),
      .x_pos(x_pos), .y_pos(y_pos), .state(state), .jump_evt(jump_evt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         x;
      int         y;
      logic [2:0] st;
      logic       je;
      int         id;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0, n_bad = 0, n_items = 0;
   bit   done = 1'b0;
   logic mon_due = 1'b0;
   bit   og_cur = 1'b1;

   // Reference player model: positions as plain integers, and the phase as ground/rise/fall.
   int m_x, m_y, m_vy, m_phase, m_age;
   bit m_face, m_move, m_jreq, m_brk, m_ext, m_a, m_d, m_w;

   function automatic void model_reset();
      m_x = X_INIT; m_y = Y_INIT; m_vy = 0; m_phase = PH_GROUND; m_age = 0;
      m_face = 1; m_move = 0; m_jreq = 0; m_brk = 0; m_ext = 0; m_a = 0; m_d = 0; m_w = 0;
   endfunction

   function automatic void model_key(input logic [7:0] c);
      if (c == 8'hF0) m_brk = 1;
      else if (c == 8'hE0) m_ext = 1;
      else begin
         if (!m_ext) begin
            if (c == 8'h1C) m_a = !m_brk;
            else if (c == 8'h23) m_d = !m_brk;
            else if (c == 8'h1D) begin
               if (!m_brk && !m_w) begin m_jreq = 1; m_age = 0; end
               m_w = !m_brk;
            end
         end
         m_brk = 0; m_ext = 0;
      end
   endfunction

   function automatic bit model_tick(input bit og, input bit hb);
      int nx;
      bit was_ground, jev;
      jev = 0;
      nx  = m_x;
      if (m_a && !m_d) begin nx = (m_x - STEP_X < 0) ? 0 : m_x - STEP_X; m_face = 0; end
      else if (m_d && !m_a) begin nx = (m_x + STEP_X > X_MAX) ? X_MAX : m_x + STEP_X; m_face = 1; end
      m_move = (nx != m_x);
      m_x = nx;
      was_ground = (m_phase == PH_GROUND);
      if (m_phase == PH_GROUND) begin
         if (m_jreq) begin
            m_y = (m_y < JUMP_V) ? 0 : m_y - JUMP_V;
            m_vy = JUMP_V - GRAVITY; m_phase = PH_RISE; jev = 1; m_jreq = 0; m_age = 0;
         end else if (!og) begin
            m_phase = PH_FALL; m_vy = GRAVITY;
         end
      end else if (m_phase == PH_RISE) begin
         if (hb || m_vy == 0) begin m_phase = PH_FALL; m_vy = GRAVITY; end
         else begin
            m_y = (m_y < m_vy) ? 0 : m_y - m_vy;
            m_vy = (m_vy < GRAVITY) ? 0 : m_vy - GRAVITY;
         end
      end else begin
         if (og) begin m_phase = PH_GROUND; m_vy = 0; end
         else if (m_y + m_vy > Y_MAX) begin m_y = Y_MAX; m_phase = PH_GROUND; m_vy = 0; end
         else begin
            m_y = m_y + m_vy;
            m_vy = (m_vy + GRAVITY > VMAX) ? VMAX : m_vy + GRAVITY;
         end
      end
      if (!was_ground && m_jreq) begin
`ifdef JACK_JUMP_BUFFER_EN
         m_age++;
         if (m_age > 4) begin m_jreq = 0; m_age = 0; end
`else
         m_jreq = 0;
`endif
      end
      return jev;
   endfunction

   function automatic void push_exp(input bit je);
      exp_t e;
      e.x  = m_x;
      e.y  = m_y;
      e.st = {m_move, m_phase != PH_GROUND, m_face};
      e.je = je;
      e.id = n_items;
      n_items++;
      sb_q.push_back(e);
   endfunction

   // Drive one cycle. On a tick, the model steps first and the key is applied after it.
   task automatic step(input bit kv, input logic [7:0] code, input bit tk, input bit r,
                       input bit og, input bit hb);
      bit je;
      @(posedge clk); #1;
      rst = 0; key_valid = kv; key_code = code; frame_tick = tk; run = r;
      on_ground = og; head_block = hb;
      if (tk) begin
         je = r ? model_tick(og, hb) : 1'b0;
         push_exp(je);
      end
      if (kv) model_key(code);
   endtask

   task automatic do_reset(input bit tk);
      @(posedge clk); #1;
      rst = 1; frame_tick = tk; key_valid = 1'($urandom_range(0, 1)); key_code = 8'h1D;
      run = 1; on_ground = og_cur; head_block = 0;
      model_reset();
      push_exp(0);
   endtask

   task automatic press(input logic [7:0] c);   step(1, c, 0, 1, og_cur, 0); endtask
   task automatic rel_key(input logic [7:0] c); press(8'hF0); press(c); endtask
   task automatic tick(input bit og, input bit hb); step(0, 8'h00, 1, 1, og, hb); endtask
   task automatic idle();                       step(0, 8'h00, 0, 1, og_cur, 0); endtask

   function automatic void chk(input string name, input int id, input int got, input int req);
      n_cmp++;
      if (got != req) begin
         n_bad++;
         $display("FAIL %s (tick %0d): got %0d, required %0d", name, id, got, req);
      end
   endfunction

   always @(posedge clk) mon_due <= (frame_tick === 1'b1) || (rst === 1'b1);

   // Monitor: after every tick or reset edge, pop and compare; otherwise jump_evt must be low.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            n_cmp++;
            if (sb_q.size() != 0) begin
               n_bad++;
               $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
         end
         if (mon_due) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_bad++;
               $display("FAIL scoreboard_underflow: got an update with no expectation, required one");
            end else begin
               e = sb_q.pop_front();
               $display("tick %0d: x=%0d y=%0d state=%b jump_evt=%b", e.id, x_pos, y_pos, state, jump_evt);
               if ($isunknown({x_pos, y_pos, state, jump_evt})) begin
                  n_bad++;
                  $display("FAIL unknown_outputs (tick %0d): got X/Z, required known values", e.id);
               end
               chk("x_pos", e.id, int'(x_pos), e.x);
               chk("y_pos", e.id, int'(y_pos), e.y);
               chk("state", e.id, int'(state), int'(e.st));
               chk("jump_evt", e.id, int'(jump_evt), int'(e.je));
            end
         end else begin
            chk("jump_evt_idle", n_items, int'(jump_evt), 0);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      logic [7:0] codes [10];
      codes = '{8'hF0, 8'hE0, 8'h1C, 8'h23, 8'h1D, 8'h1C, 8'h23, 8'h1D, 8'h29, 8'hF0};
      rst = 1; key_valid = 0; key_code = 0; frame_tick = 0; run = 1; on_ground = 1; head_block = 0;
      model_reset();
      push_exp(0);
      // Walk right, then release.
      press(8'h23); repeat (3) tick(1, 0);
      rel_key(8'h23); tick(1, 0);
      // Left saturation, then conflicting keys.
      press(8'h1C); repeat (5) tick(1, 0);
      press(8'h23); repeat (2) tick(1, 0);
      rel_key(8'h1C); rel_key(8'h23);
      // run low freezes everything.
      press(8'h23); repeat (2) step(0, 8'h00, 1, 0, 0, 0); tick(1, 0); rel_key(8'h23);
      // Fall to y = 300, land, then take the full jump arc.
      for (int g = 0; g < 200 && m_y != 300; g++) tick(0, 0);
      tick(1, 0);
      press(8'h1D); repeat (20) tick(0, 0); tick(1, 0);
      rel_key(8'h1D);
      // Ceiling hit during the rise.
      press(8'h1D); tick(0, 0); tick(0, 0); tick(0, 1); repeat (3) tick(0, 0); tick(1, 0);
      rel_key(8'h1D);
      // Extended prefix: the A make is ignored.
      press(8'hE0); press(8'h1C); repeat (2) tick(1, 0);
      // W make in the same cycle as a tick, then reset during the rise.
      step(1, 8'h1D, 1, 1, 1, 0); tick(1, 0); tick(0, 0);
      do_reset(1);
      // Jump buffer: W is pressed two ticks before landing.
      repeat (6) tick(0, 0);
      press(8'h1D); tick(0, 0); tick(1, 0); tick(1, 0); tick(1, 0);
      rel_key(8'h1D);
      // The request goes stale: six airborne ticks before landing.
      repeat (4) tick(1, 0); tick(0, 0);
      press(8'h1D); repeat (6) tick(0, 0); tick(1, 0); tick(1, 0); tick(1, 0);
      rel_key(8'h1D);
      // Long walk right into X_MAX, then a fall onto the Y_MAX floor.
      press(8'h23); repeat (256) tick(1, 0); rel_key(8'h23);
      repeat (60) tick(0, 0);
      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 399) == 0) do_reset($urandom_range(0, 1) == 0);
         else begin
            og_cur = ($urandom_range(0, 99) < 35);
            step($urandom_range(0, 99) < 30, codes[$urandom_range(0, 9)],
                 $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 85,
                 og_cur, $urandom_range(0, 99) < 15);
         end
      end
      repeat (3) idle();
      done = 1'b1;
   end
endmodule

// File: doc/jack_motion_ctrl.md
# jack_motion_ctrl

Parametrised player motion controller for Jack: decodes raw PS/2 scan bytes (make and break codes) into held-key state and integrates horizontal walking, jumping and gravity once per frame tick. It also reports the facing/airborne/moving state word consumed by the sprite selector. It sits between `ps2_keyboard` and the collision detectors (`dt_*`) and the renderer in `top`, and replaces the per-clock, make-code-only position update.

## Interface
- `X_W`, 10: width of the x coordinate.
- `Y_W`, 9: width of the y coordinate.
- `X_INIT`, 0: x after reset.
- `Y_INIT`, 0: y after reset.
- `X_MAX`, 504: largest legal x (551 − 47).
- `Y_MAX`, 360: largest legal y (401 − 41).
- `STEP_X`, 2: horizontal pixels per tick.
- `JUMP_V`, 8: initial upward speed in px/tick.
- `GRAVITY`, 1: speed change per tick.
- `VMAX`, 8: terminal fall speed, ≤ 31.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `key_code`  in  8  scan byte from `ps2_keyboard`.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid in that cycle.
- `frame_tick`  in  1  one-cycle motion-update strobe.
- `run`  in  1  when low, ticks are ignored; key decoding continues.
- `on_ground`  in  1  a solid block lies directly under the sprite at the current position.
- `head_block`  in  1  a solid block lies directly above the sprite.
- `x_pos`  out  X_W  sprite left edge.
- `y_pos`  out  Y_W  sprite top edge.
- `state`  out  3  bit0 facing (1 = right), bit1 airborne, bit2 moving.
- `jump_evt`  out  1  one-cycle pulse on jump takeoff.

## Operation
- Key decoder:
  - Byte 0xF0 sets `brk`.
  - Byte 0xE0 sets `ext`.
  - Any other byte is a code. Both flags clear after the code.
  - Codes with `ext` set are ignored.
  - 0x1C (A), 0x23 (D) and 0x1D (W) set their held bit on make and clear it on break.
  - A W make while W is not already held sets `jump_req`. Typematic repeats do not set it.
- Horizontal motion on each tick with `run` = 1:
  - A held and D not held: x −= STEP_X, saturating at 0; facing = 0.
  - D held and A not held: x += STEP_X, saturating at X_MAX; facing = 1.
  - Otherwise x is unchanged.
  - moving = 1 exactly when x changed on the tick. The flag holds until the next tick.
- Vertical FSM, evaluated on ticks. `vy` is a 5-bit unsigned speed.
  - GROUND:
    - If `jump_req`: go to RISE, y −= JUMP_V (saturating at 0), vy = JUMP_V − GRAVITY, pulse `jump_evt`, clear `jump_req`.
    - Else if !on_ground: go to FALL, vy = GRAVITY.
  - RISE:
    - If head_block or vy = 0: go to FALL, vy = GRAVITY.
    - Else y −= vy (saturating at 0) and vy −= GRAVITY, floored at 0.
  - FALL:
    - If on_ground: go to GROUND, vy = 0.
    - Else y += vy and vy = min(vy + GRAVITY, VMAX).
    - If y would exceed Y_MAX: y = Y_MAX and go to GROUND.
- airborne = (FSM ≠ GROUND).
- `jump_req` is discarded on any tick taken outside GROUND.

## Timing
- Reset values:
  - x_pos = X_INIT, y_pos = Y_INIT.
  - state = 3'b001.
  - jump_evt = 0.
  - FSM = GROUND, vy = 0.
  - Held bits, `brk`, `ext` and `jump_req` all 0.
- All outputs are registered. Position and state change on the clock edge that samples `frame_tick` = 1, so they are visible one cycle later.
- When `key_valid` and `frame_tick` are high in the same cycle, the tick uses the key state from before that edge. The byte takes effect at the next tick.
- `on_ground` and `head_block` are sampled only in tick cycles.
- `rst` overrides everything, including a tick in the same cycle. Reset mid-jump returns the FSM to GROUND at (X_INIT, Y_INIT).
- `run` = 0 freezes position, FSM and vy; ticks are ignored.

## Configuration
- `JACK_JUMP_BUFFER_EN` defined:
  - A `jump_req` raised while airborne survives up to 4 ticks outside GROUND, tracked by a 3-bit age counter.
  - It fires on the landing tick plus one (the first GROUND tick), provided it is still alive then.
- `JACK_JUMP_BUFFER_EN` undefined: a request raised outside GROUND is dropped at the next tick.

## Test plan
- Walk right: reset with on_ground = 1, byte 0x23, 3 ticks → x = 6, state = 3'b101. Then bytes F0 23 and 1 tick → x = 6, state = 3'b001.
- Left saturation and conflicting keys:
  - x = 0 with A held, 2 ticks → x = 0, moving = 0.
  - A and D both held → x unchanged.
- Jump arc from y = 300 on the ground: byte 0x1D, then ticks with on_ground = 0.
  - First tick: y = 292 and `jump_evt` pulses.
  - Apex y = 264 reached after 8 ticks.
  - Then FALL, with y increasing by 1, 2, 3, … until on_ground = 1 returns GROUND.
- Ceiling: during RISE at y = 285, head_block = 1 → the next tick enters FALL with y unchanged. Floor: y = 355 falling at vy = 8 → y = 360, GROUND.
- Extended and simultaneous input:
  - Bytes E0 1C → no movement.
  - W make in the same cycle as a tick → no jump on that tick; jump occurs on the following tick.
  - rst during RISE → (0, 0), state = 3'b001.
- Jump buffer: W pressed 2 ticks before landing.
  - With `JACK_JUMP_BUFFER_EN` → the jump fires on the first GROUND tick.
  - Without it → no jump.
